// File: rtl/gf_alu_if.sv
// Request/response bundle for the GF(p) arithmetic unit.
// The controller drives the master side and the ALU drives the slave side.
interface gf_alu_if #(
  parameter int WIDTH = 32
);
  logic             i_valid;
  logic             o_ready;
  logic [1:0]       i_op;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic [WIDTH-1:0] i_prime;
  logic             o_valid;
  logic [WIDTH-1:0] o_result;
  logic             o_err;

  modport master (
    output i_valid, i_op, i_a, i_b, i_prime,
    input  o_ready, o_valid, o_result, o_err
  );

  modport slave (
    input  i_valid, i_op, i_a, i_b, i_prime,
    output o_ready, o_valid, o_result, o_err
  );
endinterface

// File: rtl/gf_alu.sv
// GF(p) add/sub/mult/div unit: bit-serial interleaved multiply, binary-inversion divide.
// Optional GF_ALU_RANGE_CHECK_EN rejects operands >= p at accept with o_err.
module gf_alu #(
  parameter int WIDTH = 32
) (
  input  logic     i_clk,
  input  logic     i_rst_n,
  gf_alu_if.slave  bus
);
  localparam int CW = $clog2(2 * WIDTH + 1);
  localparam logic [CW-1:0] MUL_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(2 * WIDTH - 1);

  typedef enum logic [2:0] {IDLE, ADDSUB, MUL, DIV, DONE} state_t;

  state_t           state;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, p_q;
  logic [WIDTH+1:0] acc;
  logic [WIDTH-1:0] u, v, x1, x2;
  logic [CW-1:0]    cnt;
  logic             range_err_q;
  logic             ready_q, valid_q, err_q;
  logic [WIDTH-1:0] result_q;

  logic             range_bad;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] add_res, sub_res;
  logic [WIDTH+1:0] p_ext, mul_dbl, mul_r1, mul_r2;
  logic [WIDTH-1:0] nu, nv, nx1, nx2;
  logic             done, done_err;
  logic [WIDTH-1:0] done_res;

`ifdef GF_ALU_RANGE_CHECK_EN
  assign range_bad = (bus.i_a >= bus.i_prime) || (bus.i_b >= bus.i_prime);
`else
  assign range_bad = 1'b0;
`endif

  function automatic logic [WIDTH-1:0] half(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] p);
    logic [WIDTH:0] s;
    s = x[0] ? ({1'b0, x} + {1'b0, p}) : {1'b0, x};
    return WIDTH'(s >> 1);
  endfunction

  function automatic logic [WIDTH-1:0] submod(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                              input logic [WIDTH-1:0] p);
    return (x >= y) ? (x - y) : WIDTH'({1'b0, x} + {1'b0, p} - {1'b0, y});
  endfunction

  always_comb begin
    sum     = {1'b0, a_q} + {1'b0, b_q};
    add_res = (sum >= {1'b0, p_q}) ? WIDTH'(sum - {1'b0, p_q}) : sum[WIDTH-1:0];
    sub_res = submod(a_q, b_q, p_q);

    // One MSB-first multiply step; acc < p keeps 2*acc + b below 3p.
    p_ext   = {2'b00, p_q};
    mul_dbl = (acc << 1) + (a_q[WIDTH-1] ? {2'b00, b_q} : '0);
    mul_r1  = (mul_dbl >= p_ext) ? (mul_dbl - p_ext) : mul_dbl;
    mul_r2  = (mul_r1 >= p_ext) ? (mul_r1 - p_ext) : mul_r1;

    nu  = u;
    nv  = v;
    nx1 = x1;
    nx2 = x2;
    if (!u[0]) begin
      nu  = u >> 1;
      nx1 = half(x1, p_q);
    end else if (!v[0]) begin
      nv  = v >> 1;
      nx2 = half(x2, p_q);
    end else if (u >= v) begin
      nu  = u - v;
      nx1 = submod(x1, x2, p_q);
    end else begin
      nv  = v - u;
      nx2 = submod(x2, x1, p_q);
    end
  end

  // Completion decision per state; u == 0 covers b = 0 and degenerate moduli.
  always_comb begin
    done     = 1'b0;
    done_err = 1'b0;
    done_res = '0;
    case (state)
      ADDSUB: begin
        done = 1'b1;
        if (range_err_q) done_err = 1'b1;
        else done_res = (op_q == 2'd1) ? sub_res : add_res;
      end
      MUL: begin
        done     = (cnt == MUL_LAST);
        done_res = mul_r2[WIDTH-1:0];
      end
      DIV: begin
        if (u == '0) begin
          done     = 1'b1;
          done_err = 1'b1;
        end else if (u == WIDTH'(1)) begin
          done     = 1'b1;
          done_res = x1;
        end else if (v == WIDTH'(1)) begin
          done     = 1'b1;
          done_res = x2;
        end else if (nu == WIDTH'(1)) begin
          done     = 1'b1;
          done_res = nx1;
        end else if (nv == WIDTH'(1)) begin
          done     = 1'b1;
          done_res = nx2;
        end else if (cnt == DIV_LAST) begin
          done     = 1'b1;
          done_res = nx1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      p_q         <= '0;
      acc         <= '0;
      u           <= '0;
      v           <= '0;
      x1          <= '0;
      x2          <= '0;
      cnt         <= '0;
      range_err_q <= 1'b0;
      ready_q     <= 1'b1;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      result_q    <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        IDLE, DONE: begin
          ready_q <= 1'b1;
          state   <= IDLE;
          if (bus.i_valid) begin
            op_q        <= bus.i_op;
            a_q         <= bus.i_a;
            b_q         <= bus.i_b;
            p_q         <= bus.i_prime;
            acc         <= '0;
            cnt         <= '0;
            u           <= bus.i_b;
            v           <= bus.i_prime;
            x1          <= bus.i_a;
            x2          <= '0;
            range_err_q <= range_bad;
            ready_q     <= 1'b0;
            if (range_bad) state <= ADDSUB;
            else begin
              case (bus.i_op)
                2'd2:    state <= MUL;
                2'd3:    state <= DIV;
                default: state <= ADDSUB;
              endcase
            end
          end
        end
        MUL: begin
          acc <= mul_r2;
          a_q <= a_q << 1;
          cnt <= cnt + 1'b1;
        end
        DIV: begin
          if (!done) begin
            u   <= nu;
            v   <= nv;
            x1  <= nx1;
            x2  <= nx2;
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
      if (done) begin
        result_q <= done_res;
        err_q    <= done_err;
        valid_q  <= 1'b1;
        ready_q  <= 1'b1;
        state    <= DONE;
      end
    end
  end

  assign bus.o_ready  = ready_q;
  assign bus.o_valid  = valid_q;
  assign bus.o_result = result_q;
  assign bus.o_err    = err_q;
endmodule

// File: tb/tb_gf_alu.sv
// Directed vector bench for gf_alu: table of hand-computed results plus reset and back-to-back sequences.
// Build with GF_ALU_RANGE_CHECK_EN to also exercise the operand range check.
module tb_gf_alu;
  localparam int WIDTH     = 32;
  localparam int MAX_EDGES = 200;
  localparam logic [WIDTH-1:0] PBIG = 32'hFFFF_FFFB;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;

  gf_alu_if #(.WIDTH(WIDTH)) bus ();

  gf_alu #(.WIDTH(WIDTH)) dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .bus    (bus)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] res;
    logic             err;
    int               lat;
  } vec_t;

  vec_t vecs[14];

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual,
                             input logic [WIDTH-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Issue one operation and report latency (0 = no completion within the bound).
  task automatic applyStimulus(input logic [1:0] op, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] p,
                               output int lat, output logic [WIDTH-1:0] res, output logic err);
    int waits;
    waits = 0;
    lat   = 0;
    res   = '0;
    err   = 1'b0;
    @(negedge i_clk);
    while (!bus.o_ready && waits < MAX_EDGES) begin
      @(negedge i_clk);
      waits++;
    end
    bus.i_valid = 1'b1;
    bus.i_op    = op;
    bus.i_a     = a;
    bus.i_b     = b;
    bus.i_prime = p;
    for (int e = 1; e <= MAX_EDGES; e++) begin
      @(posedge i_clk);
      #1;
      if (e == 1) bus.i_valid = 1'b0;
      if (bus.o_valid) begin
        lat = e;
        res = bus.o_result;
        err = bus.o_err;
        break;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int               lat;
    logic [WIDTH-1:0] res;
    logic             err;
    int               nvalid;

    // op, a, b, p, expected result, expected err, expected latency (0 = bound only)
    vecs[0]  = '{2'd0, PBIG - 1, 32'd2, PBIG, 32'd1, 1'b0, 2};
    vecs[1]  = '{2'd0, 32'd6, 32'd6, 32'd7, 32'd5, 1'b0, 2};
    vecs[2]  = '{2'd0, 32'd0, 32'd0, 32'd7, 32'd0, 1'b0, 2};
    vecs[3]  = '{2'd1, 32'd3, 32'd5, 32'd7, 32'd5, 1'b0, 2};
    vecs[4]  = '{2'd1, 32'd5, 32'd5, 32'd7, 32'd0, 1'b0, 2};
    vecs[5]  = '{2'd1, 32'd0, 32'd6, 32'd7, 32'd1, 1'b0, 2};
    vecs[6]  = '{2'd2, PBIG - 1, PBIG - 1, PBIG, 32'd1, 1'b0, 33};
    vecs[7]  = '{2'd2, 32'd0, PBIG - 1, PBIG, 32'd0, 1'b0, 33};
    vecs[8]  = '{2'd2, 32'd2, 32'h8000_0000, PBIG, 32'd5, 1'b0, 33};
    vecs[9]  = '{2'd3, 32'd3, 32'd2, 32'd7, 32'd5, 1'b0, 2};
    vecs[10] = '{2'd3, 32'd3, 32'd0, 32'd7, 32'd0, 1'b1, 2};
    vecs[11] = '{2'd3, 32'd4, 32'd1, 32'd7, 32'd4, 1'b0, 2};
    vecs[12] = '{2'd3, 32'd1, 32'd3, 32'd13, 32'd9, 1'b0, 5};
    vecs[13] = '{2'd3, 32'd6, 32'd3, PBIG, 32'd2, 1'b0, 0};

    bus.i_valid = 1'b0;
    bus.i_op    = '0;
    bus.i_a     = '0;
    bus.i_b     = '0;
    bus.i_prime = '0;
    repeat (3) @(negedge i_clk);
    checkOutput("reset o_ready", WIDTH'(bus.o_ready), 1);
    checkOutput("reset o_valid", WIDTH'(bus.o_valid), 0);
    checkOutput("reset o_result", bus.o_result, 0);
    checkOutput("reset o_err", WIDTH'(bus.o_err), 0);
    i_rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].p, lat, res, err);
      checkOutput($sformatf("vec%0d result", i), res, vecs[i].res);
      checkOutput($sformatf("vec%0d err", i), WIDTH'(err), WIDTH'(vecs[i].err));
      if (vecs[i].lat != 0)
        checkOutput($sformatf("vec%0d latency", i), WIDTH'(lat), WIDTH'(vecs[i].lat));
      else
        checkOutput($sformatf("vec%0d latency bound", i), WIDTH'(lat > 0 && lat <= 2 * WIDTH + 1), 1);
    end

    // Result and error stay held while idle.
    repeat (3) @(negedge i_clk);
    checkOutput("held result", bus.o_result, 32'd2);
    checkOutput("held err", WIDTH'(bus.o_err), 0);

    // Back-to-back: next add presented while DONE is showing.
    applyStimulus(2'd0, 32'd6, 32'd6, 32'd7, lat, res, err);
    checkOutput("b2b first result", res, 32'd5);
    bus.i_valid = 1'b1;
    bus.i_op    = 2'd0;
    bus.i_a     = 32'd1;
    bus.i_b     = 32'd2;
    bus.i_prime = 32'd7;
    @(posedge i_clk);
    #1;
    bus.i_valid = 1'b0;
    checkOutput("b2b accepted on DONE edge", WIDTH'(bus.o_ready), 0);
    checkOutput("b2b no double o_valid", WIDTH'(bus.o_valid), 0);
    @(posedge i_clk);
    #1;
    checkOutput("b2b second o_valid", WIDTH'(bus.o_valid), 1);
    checkOutput("b2b second result", bus.o_result, 32'd3);

    // Reset 10 cycles into a multiply aborts it.
    @(negedge i_clk);
    bus.i_valid = 1'b1;
    bus.i_op    = 2'd2;
    bus.i_a     = PBIG - 1;
    bus.i_b     = PBIG - 1;
    bus.i_prime = PBIG;
    @(posedge i_clk);
    #1;
    bus.i_valid = 1'b0;
    repeat (10) @(posedge i_clk);
    #1;
    i_rst_n = 1'b0;
    #1;
    checkOutput("midreset o_ready", WIDTH'(bus.o_ready), 1);
    checkOutput("midreset o_valid", WIDTH'(bus.o_valid), 0);
    checkOutput("midreset o_result", bus.o_result, 0);
    checkOutput("midreset o_err", WIDTH'(bus.o_err), 0);
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    nvalid = 0;
    for (int e = 0; e < 40; e++) begin
      @(posedge i_clk);
      #1;
      if (bus.o_valid) nvalid++;
    end
    checkOutput("no o_valid after abort", WIDTH'(nvalid), 0);
    applyStimulus(2'd0, 32'd6, 32'd6, 32'd7, lat, res, err);
    checkOutput("post-reset add result", res, 32'd5);
    checkOutput("post-reset add latency", WIDTH'(lat), 2);

`ifdef GF_ALU_RANGE_CHECK_EN
    applyStimulus(2'd2, 32'd9, 32'd3, 32'd7, lat, res, err);
    checkOutput("range mult err", WIDTH'(err), 1);
    checkOutput("range mult result", res, 0);
    checkOutput("range mult latency", WIDTH'(lat), 2);
    applyStimulus(2'd0, 32'd1, 32'd2, 32'd7, lat, res, err);
    checkOutput("range b2b add result", res, 32'd3);
    checkOutput("range b2b add err", WIDTH'(err), 0);
    checkOutput("range b2b add latency", WIDTH'(lat), 2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/gf_alu.md
# gf_alu

Parametrised GF(p) arithmetic unit for the ECC datapath: modular add, subtract, multiply and divide on WIDTH-bit operands modulo an odd prime supplied with each operation. Operations are issued on a valid/ready handshake and complete with a one-cycle `o_valid` pulse and a held result. Multiply is bit-serial interleaved; divide is a single-pass binary inversion that computes a·b⁻¹ mod p directly, with divide-by-zero flagged. The block sits under the point-arithmetic controller, which issues one operation at a time.

## Interface

Parameters:
- WIDTH, 32, operand/prime/result width in bits (≥ 8).

Ports:
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_valid  in  1  operation request.
- o_ready  out  1  unit idle; the operation is accepted on a rising edge where i_valid && o_ready.
- i_op  in  2  0 = add, 1 = sub, 2 = mult, 3 = div.
- i_a  in  WIDTH  operand a.
- i_b  in  WIDTH  operand b.
- i_prime  in  WIDTH  modulus p: odd, > 2, < 2^WIDTH.
- o_valid  out  1  one-cycle completion pulse.
- o_result  out  WIDTH  result in [0, p-1]; held until the next completion.
- o_err  out  1  error flag for the last operation; held with o_result.

## Operation

- Accept edge: latch i_op, i_a, i_b and i_prime; o_ready goes to 0. Inputs are ignored until o_ready returns to 1.
- States: IDLE, ADDSUB, MUL, DIV, DONE.
  - DONE drives o_valid = 1 and o_ready = 1 for one cycle, then returns to IDLE.
  - A request accepted on the DONE edge is taken as a normal accept, so back-to-back issue is legal.
- add: s = a + b at WIDTH+1 bits; result = s − p if s ≥ p, else s.
- sub: result = a − b if a ≥ b, else a + p − b, computed at WIDTH+1 bits.
- mult (MSB-first interleaved): acc = 0. For i = WIDTH−1 down to 0, in one cycle each:
  - acc = 2·acc + a[i]·b
  - then subtract p at most twice, while acc ≥ p.
  - acc is WIDTH+2 bits wide.
- div: computes a·b⁻¹ mod p.
  - Init: u = b, v = p, x1 = a, x2 = 0.
  - Each cycle, while u ≠ 1 and v ≠ 1, do exactly one step, in priority order:
    - u even: u >>= 1, x1 = half(x1).
    - v even: v >>= 1, x2 = half(x2).
    - u ≥ v: u −= v, x1 = x1 − x2 mod p.
    - else: v −= u, x2 = x2 − x1 mod p.
  - half(x) = x/2 if x is even, else (x + p)/2, computed at WIDTH+1 bits.
  - Exit: result = x1 if u = 1, else x2.
- div with b = 0: no iteration; o_result = 0, o_err = 1.
- div with b = 1: exits immediately; result = a.
- o_err = 0 for every other completion, except as described under Configuration.
- Behaviour with a non-prime or even p is undefined; it must not hang beyond the latency bound.

## Timing

- Reset values: o_ready = 1, o_valid = 0, o_result = 0, o_err = 0, state IDLE.
- Reset asserted mid-operation aborts the operation at once; no o_valid is produced.
- Latency N = number of rising edges from the accept edge to the edge that raises o_valid. o_result and o_err update on that same edge.
  - add, sub: N = 2 (ADDSUB, then DONE).
  - mult: N = WIDTH + 1.
  - div: N = iterations + 1, with iterations ≤ 2·WIDTH. Divide-by-zero gives N = 2.
- o_valid is never high on two consecutive cycles for a single operation.

## Configuration

- GF_ALU_RANGE_CHECK_EN defined:
  - At accept, if i_a ≥ i_prime or i_b ≥ i_prime, the operation is not executed.
  - Completion comes at N = 2 with o_result = 0 and o_err = 1.
- Not defined: no check is made. Operands are required to be < p; results for out-of-range operands are unspecified.

## Test plan

- Add, WIDTH = 32, p = 0xFFFFFFFB, a = p−1, b = 2 -> o_result = 1, o_err = 0, N = 2.
- Sub, p = 7, a = 3, b = 5 -> o_result = 5; then a = 5, b = 5 -> o_result = 0.
- Mult, p = 0xFFFFFFFB, a = b = p−1 -> o_result = 1 with o_valid at N = 33; also a = 0 -> o_result = 0.
- Div, p = 7, a = 3, b = 2 -> o_result = 5 within 65 edges. Then b = 0 -> o_err = 1, o_result = 0, N = 2. Then b = 1, a = 4 -> o_result = 4.
- Reset pulled low 10 cycles into a mult -> all outputs return to reset values, no o_valid. The next add, p = 7, 6 + 6 -> o_result = 5.
- With GF_ALU_RANGE_CHECK_EN: mult, p = 7, a = 9 -> o_err = 1 at N = 2. Back-to-back add issued on the DONE edge -> accepted with no lost cycle.
